// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Owner encoding, legal byte-enable patterns, DM word-address width.
package dm_pkg;

  localparam int DM_AW = 12;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;

endpackage

// File: rtl/dm_port_arbiter_be_check.sv
// Legal byte-enable decoder: word, aligned half or single byte.
// Ports: be (4) in, legal (1) out.
module be_check
  import dm_pkg::*;
(
  input  logic [3:0] be,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (be)
      BE_WORD,
      BE_HALF0, BE_HALF1,
      BE_BYTE0, BE_BYTE1,
      BE_BYTE2, BE_BYTE3: legal = 1'b1;
      default:            legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter with burst lock in front of the data memory.
// Ports: m0/m1 request bundles, per-port gnt/rvalid/rdata/err, dm_* lines.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int AW        = DM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic          dm_wr,
  output logic [3:0]    dm_be,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata
);

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  owner_t     owner, owner_nxt;
  owner_t     last, last_nxt;
  owner_t     gsel;
  logic [3:0] burst_cnt, cnt_nxt;
  logic       own_req, oth_req, keep;
  logic       sel1, we, legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWN_NONE;
      burst_cnt <= 4'd0;
      last      <= OWN_M1;
    end else begin
      owner     <= owner_nxt;
      burst_cnt <= cnt_nxt;
      last      <= last_nxt;
    end
  end

  always_comb begin
    own_req   = 1'b0;
    oth_req   = 1'b0;
    gsel      = OWN_NONE;
    owner_nxt = owner;
    cnt_nxt   = burst_cnt;
    last_nxt  = last;
    case (owner)
      OWN_M0: begin
        own_req = m0_req;
        oth_req = m1_req;
      end
      OWN_M1: begin
        own_req = m1_req;
        oth_req = m0_req;
      end
      default: ;
    endcase
    // Owner keeps the port until the burst limit, unless nobody else waits.
    keep = (owner != OWN_NONE) && own_req &&
           ((burst_cnt < MAXB) || !oth_req);
    priority case (1'b1)
      reset:             gsel = OWN_NONE;
      keep:              gsel = owner;
      (m0_req & m1_req): gsel = (last == OWN_M0) ? OWN_M1 : OWN_M0;
      m0_req:            gsel = OWN_M0;
      m1_req:            gsel = OWN_M1;
      default:           gsel = OWN_NONE;
    endcase
    if (gsel == OWN_NONE) begin
      owner_nxt = OWN_NONE;
      cnt_nxt   = 4'd0;
    end else if (gsel == owner) begin
      cnt_nxt = (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;
    end else begin
      owner_nxt = gsel;
      cnt_nxt   = 4'd1;
      last_nxt  = gsel;
    end
  end

  assign m0_gnt = (gsel == OWN_M0);
  assign m1_gnt = (gsel == OWN_M1);

  assign sel1     = m1_gnt;
  assign dm_addr  = sel1 ? m1_addr  : m0_addr;
  assign dm_be    = sel1 ? m1_be    : m0_be;
  assign dm_wdata = sel1 ? m1_wdata : m0_wdata;
  assign we       = sel1 ? m1_we    : m0_we;

  be_check u_be_check (
    .be    (dm_be),
    .legal (legal)
  );

  assign dm_wr = (m0_gnt | m1_gnt) & we & legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= 32'd0;
      m1_rdata  <= 32'd0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      m0_err    <= m0_gnt & m0_we & ~legal;
      m1_err    <= m1_gnt & m1_we & ~legal;
      if (m0_gnt & ~m0_we) m0_rdata <= dm_rdata;
      if (m1_gnt & ~m1_we) m1_rdata <= dm_rdata;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural 4096x32 DM.
// Checks reset, reads, ties, burst limit, partial/illegal writes, async reset.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [11:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_wr;
  logic [3:0]  dm_be;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;

  logic [31:0] mem [0:4095];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.MAX_BURST(4), .AW(12)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_wr(dm_wr), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  assign dm_rdata = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_wr) begin
      for (int b = 0; b < 4; b++)
        if (dm_be[b]) mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_be = 4'hF;
    m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = 4'hF;
    m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    #2;
    reset = 1'b0;
    cyc();
  endtask

  logic [1:0] burst_exp [10];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h001] = 32'h0000_0011;
    mem[12'h002] = 32'h0000_0022;
    mem[12'h010] = 32'hDEAD_BEEF;
    mem[12'h020] = 32'h1234_5678;
    mem[12'h030] = 32'hCAFE_F00D;
    mem[12'h040] = 32'h55AA_55AA;
    burst_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                  2'b10, 2'b10, 2'b10, 2'b01, 2'b01};

    // Reset: requests are blocked while reset is high.
    idle();
    m0_req = 1; m0_we = 1;
    #2;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_dm_wr", dm_wr, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_err", m1_err, 0);
    #11;
    idle();
    reset = 1'b0;
    cyc();

    // Single read.
    m0_req = 1; m0_addr = 12'h010;
    #1;
    chk("rd_m0_gnt", m0_gnt, 1);
    chk("rd_m1_gnt", m1_gnt, 0);
    chk("rd_dm_wr", dm_wr, 0);
    chk("rd_dm_addr", dm_addr, 32'h010);
    cyc();
    idle();
    #1;
    chk("rd_rvalid", m0_rvalid, 1);
    chk("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
    cyc();
    chk("rd_rvalid_off", m0_rvalid, 0);
    chk("rd_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

    // Tie straight after reset.
    do_reset();
    m0_req = 1; m0_addr = 12'h001;
    m1_req = 1; m1_addr = 12'h002;
    #1;
    chk("tie_m0_gnt", m0_gnt, 1);
    chk("tie_m1_gnt", m1_gnt, 0);
    cyc();
    m0_req = 0;
    #1;
    chk("tie2_m1_gnt", m1_gnt, 1);
    chk("tie2_m0_rvalid", m0_rvalid, 1);
    chk("tie2_m0_rdata", m0_rdata, 32'h11);
    cyc();
    m1_req = 0;
    #1;
    chk("tie3_m1_rvalid", m1_rvalid, 1);
    chk("tie3_m1_rdata", m1_rdata, 32'h22);
    cyc();
    m0_req = 1; m1_req = 1;
    #1;
    chk("tie_last_m1", {m1_gnt, m0_gnt}, 2'b01);
    cyc();
    idle();
    cyc();

    // Burst limit of 4 with both requesting.
    for (int i = 0; i < 10; i++) begin
      m0_req = 1;
      if (i >= 1) m1_req = 1;
      #1;
      chk($sformatf("burst_%0d", i), {m1_gnt, m0_gnt}, burst_exp[i]);
      cyc();
    end
    idle();
    cyc();

    // Partial write of the upper half, then read back.
    m1_req = 1; m1_we = 1; m1_be = 4'b1100;
    m1_addr = 12'h020; m1_wdata = 32'hABCD_0000;
    #1;
    chk("pw_m1_gnt", m1_gnt, 1);
    chk("pw_dm_wr", dm_wr, 1);
    chk("pw_dm_be", dm_be, 4'b1100);
    chk("pw_dm_wdata", dm_wdata, 32'hABCD_0000);
    cyc();
    idle();
    m0_req = 1; m0_addr = 12'h020;
    #1;
    chk("pw_rd_gnt", m0_gnt, 1);
    cyc();
    idle();
    #1;
    chk("pw_rd_rvalid", m0_rvalid, 1);
    chk("pw_rd_rdata", m0_rdata, 32'hABCD_5678);
    chk("pw_m1_err", m1_err, 0);

    // Illegal byte enable.
    m0_req = 1; m0_we = 1; m0_be = 4'b0110;
    m0_addr = 12'h030; m0_wdata = 32'hFFFF_FFFF;
    #1;
    chk("ibe_m0_gnt", m0_gnt, 1);
    chk("ibe_dm_wr", dm_wr, 0);
    cyc();
    idle();
    #1;
    chk("ibe_err", m0_err, 1);
    chk("ibe_rvalid", m0_rvalid, 0);
    cyc();
    chk("ibe_err_off", m0_err, 0);
    m0_req = 1; m0_addr = 12'h030;
    cyc();
    idle();
    #1;
    chk("ibe_mem", m0_rdata, 32'hCAFE_F00D);

    // Async reset while a read is pending and a write is on the bus.
    m0_req = 1; m0_addr = 12'h010;
    #1;
    chk("ar_gnt", m0_gnt, 1);
    cyc();
    m0_we = 1; m0_be = 4'hF;
    m0_addr = 12'h040; m0_wdata = 32'h1111_1111;
    #1;
    chk("ar_rvalid_pre", m0_rvalid, 1);
    chk("ar_dm_wr_pre", dm_wr, 1);
    reset = 1'b1;
    #1;
    chk("ar_gnt_drop", m0_gnt, 0);
    chk("ar_dm_wr_drop", dm_wr, 0);
    chk("ar_rvalid_drop", m0_rvalid, 0);
    chk("ar_rdata_clr", m0_rdata, 0);
    cyc();
    idle();
    #1;
    reset = 1'b0;
    cyc();
    m0_req = 1; m0_addr = 12'h040;
    m1_req = 1; m1_addr = 12'h010;
    #1;
    chk("ar_tie", {m1_gnt, m0_gnt}, 2'b01);
    cyc();
    m0_req = 0;
    #1;
    chk("ar_no_commit", m0_rdata, 32'h55AA_55AA);
    cyc();
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
